// File: rtl/moving_avg_filter.sv
// Boxcar moving-average filter over a runtime-selectable window of 2^k samples,
// with sample-valid handshake, fill tracking and flush.
module moving_avg_filter #(
  parameter int unsigned VAL_RES        = 16,
  parameter int unsigned MAX_LOG2_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         win_log2,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [VAL_RES-1:0] in_data,
  output logic               out_valid,
  output logic [VAL_RES-1:0] out_data,
  output logic               out_full
);

  localparam int unsigned DEPTH = 1 << MAX_LOG2_DEPTH;
  localparam int unsigned AW    = MAX_LOG2_DEPTH;
  localparam int unsigned FC_W  = MAX_LOG2_DEPTH + 1;
  localparam int unsigned SUM_W = VAL_RES + MAX_LOG2_DEPTH;
  localparam int unsigned K_W   = 4;

  logic [VAL_RES-1:0] mem_q [DEPTH];

  logic [AW-1:0]      wp_q, wp_d;
  logic [FC_W-1:0]    fc_q, fc_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               out_valid_q, out_valid_d;
  logic [VAL_RES-1:0] out_data_q, out_data_d;
  logic               out_full_q, out_full_d;

  logic [K_W-1:0]     k_eff_c;
  logic               clear_c;
  logic [FC_W-1:0]    win_size_c;
  logic [SUM_W-1:0]   sum_base_c;
  logic [FC_W-1:0]    fc_base_c;
  logic [AW-1:0]      rd_idx_c;
  logic [VAL_RES-1:0] oldest_c;

  // Window exponent saturation and clear detection; clear is applied before any accept.
  always_comb begin
    k_eff_c    = (win_log2 > K_W'(MAX_LOG2_DEPTH)) ? K_W'(MAX_LOG2_DEPTH) : win_log2;
    clear_c    = flush || (k_eff_c != k_q);
    k_d        = clear_c ? k_eff_c : k_q;
    win_size_c = FC_W'(1) << k_d;
    sum_base_c = clear_c ? '0 : sum_q;
    fc_base_c  = clear_c ? '0 : fc_q;
    // With k = MAX the oldest slot aliases wp itself; it is read before being overwritten.
    rd_idx_c   = wp_q - win_size_c[AW-1:0];
    oldest_c   = (fc_base_c >= win_size_c) ? mem_q[rd_idx_c] : '0;
  end

  // Next-state and registered output computation.
  always_comb begin
    wp_d        = wp_q;
    fc_d        = fc_base_c;
    sum_d       = sum_base_c;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_full_d  = clear_c ? 1'b0 : out_full_q;
    if (in_valid) begin
      sum_d       = sum_base_c + SUM_W'(in_data) - SUM_W'(oldest_c);
      fc_d        = (fc_base_c == FC_W'(DEPTH)) ? fc_base_c : fc_base_c + FC_W'(1);
      wp_d        = wp_q + AW'(1);
      out_valid_d = 1'b1;
      out_data_d  = VAL_RES'(sum_d >> k_d);
      out_full_d  = (fc_d >= win_size_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q        <= '0;
      fc_q        <= '0;
      sum_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_full_q  <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      fc_q        <= fc_d;
      sum_q       <= sum_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_full_q  <= out_full_d;
    end
  end

  // Sample buffer carries no reset; fc gates every read of stale contents.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      mem_q[wp_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_full  = out_full_q;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Randomized scoreboard bench for moving_avg_filter against a window-queue reference model.
module tb_moving_avg_filter;

  localparam int unsigned VAL_RES = 16;
  localparam int unsigned MAXL    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         win_log2;
  logic               flush;
  logic               in_valid;
  logic [VAL_RES-1:0] in_data;
  logic               out_valid;
  logic [VAL_RES-1:0] out_data;
  logic               out_full;

  moving_avg_filter #(.VAL_RES(VAL_RES), .MAX_LOG2_DEPTH(MAXL)) dut (
    .clk(clk), .rst(rst), .win_log2(win_log2), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_full(out_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               v;
    logic [VAL_RES-1:0] d;
    logic               f;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Reference model: samples since the last clear, capped at the window length.
  int unsigned        m_k = 0;
  int unsigned        m_win[$];
  logic [VAL_RES-1:0] m_data = '0;
  logic               m_full = 1'b0;

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [3:0] w, input logic [VAL_RES-1:0] d);
    int unsigned keff;
    bit          clr;
    longint      s;
    exp_t        e;
    rst = r; flush = f; in_valid = v; win_log2 = w; in_data = d;
    if (r) begin
      m_win.delete();
      m_k = 0; m_data = '0; m_full = 1'b0;
      e.v = 1'b0;
    end else begin
      keff = (int'(w) > MAXL) ? MAXL : int'(w);
      clr  = f || (keff != m_k);
      if (clr) begin
        m_win.delete();
        m_k = keff;
      end
      if (v) begin
        m_win.push_back(int'(d));
        if (m_win.size() > (1 << m_k)) void'(m_win.pop_front());
        s = 0;
        foreach (m_win[i]) s += longint'(m_win[i]);
        m_data = VAL_RES'(s >> m_k);
        m_full = (m_win.size() == (1 << m_k));
      end else if (clr) begin
        m_full = 1'b0;
      end
      e.v = v;
    end
    e.d = m_data;
    e.f = m_full;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every post-edge cycle against the scoreboard entry for that edge.
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== e.v) begin
        failures++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cycle, out_valid, e.v);
      end
      checks++;
      if (out_full !== e.f) begin
        failures++;
        $display("FAIL out_full cyc=%0d got=%b exp=%b", cycle, out_full, e.f);
      end
      checks++;
      if (out_data !== e.d) begin
        failures++;
        $display("FAIL out_data cyc=%0d got=%h exp=%h", cycle, out_data, e.d);
      end
    end
  end

  initial begin
    logic [3:0]         w;
    logic [VAL_RES-1:0] d;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; win_log2 = '0; in_data = '0;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 16'h1234);

    // k=0 pass-through
    drive(0, 0, 1, 0, 16'd5);
    drive(0, 0, 1, 0, 16'd9);
    drive(0, 0, 1, 0, 16'hFFFF);
    drive(0, 0, 0, 0, 0);

    // k=2 ramp
    for (int i = 1; i <= 5; i++) drive(0, 0, 1, 2, VAL_RES'(4 * i));

    // k=4 saturated samples across wp wrap
    for (int i = 0; i < 40; i++) drive(0, 0, 1, 4, 16'hFFFF);

    // k=2 full of 100, then window shrink with a sample on the same cycle
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 2, 16'd100);
    drive(0, 0, 1, 1, 16'd200);
    drive(0, 0, 1, 1, 16'd200);

    // flush without and with a sample
    drive(0, 0, 1, 3, 16'd40);
    drive(0, 1, 0, 3, 0);
    drive(0, 0, 0, 3, 0);
    drive(0, 1, 1, 3, 16'd8);

    // mid-stream reset at k=2
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 2, 16'd77);
    drive(1, 0, 1, 2, 16'd99);
    drive(0, 0, 1, 2, 16'd12);
    drive(0, 0, 1, 2, 16'd12);

    // saturation of win_log2 above MAX
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 4'd9 + 4'(i % 3), VAL_RES'(1000 + i));

    // randomized mix
    w = 4'd2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) w = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       d = 16'hFFFF;
        1:       d = VAL_RES'($urandom_range(0, 15));
        default: d = VAL_RES'($urandom);
      endcase
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 7, w, d);
    end

    drive(0, 0, 0, w, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
